// File: rtl/i2c_host_bus_master_pkg.sv
// Shared definitions for the I2C host register-bus master: register map,
// FSM state encoding and phase-counter sizing.
package i2c_host_pkg;

  // Register addresses of the I2C core as seen on add_bus.
  localparam logic [7:0] REG_RR   = 8'h00;
  localparam logic [7:0] REG_PRER = 8'h02;
  localparam logic [7:0] REG_CTR  = 8'h04;
  localparam logic [7:0] REG_SR   = 8'h08;
  localparam logic [7:0] REG_TO   = 8'h0A;
  localparam logic [7:0] REG_ADDR = 8'h0C;
  localparam logic [7:0] REG_DR   = 8'h0E;

  // Width of the per-phase cycle counter; phase lengths are 1..2**CNT_W-1.
  localparam int CNT_W   = 4;
  localparam int CYC_MAX = (1 << CNT_W) - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    GAP  = 3'd3,
    RESP = 3'd4
  } state_t;

  // Counter preload for a phase lasting 'cycles' clocks (counts down to 0).
  function automatic cnt_t phase_load(input int cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/i2c_host_bus_master_if.sv
// Command/response handshake plus the as/ds/rw register bus of the
// I2C host master. 'master' is the initiator side, 'slave' the far side
// (host sequencer plus I2C register block).
interface i2c_host_bus_master_if;
  import i2c_host_pkg::*;

  // Command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;

  // Response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_write;
  logic [7:0] rsp_rdata;

  // Register bus towards the I2C core
  logic [7:0] add_bus;
  logic [7:0] bus_wdata;
  logic       as;
  logic       ds;
  logic       rw;
  logic [7:0] bus_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, bus_rdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    output add_bus, bus_wdata, as, ds, rw
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata,
    input  add_bus, bus_wdata, as, ds, rw
  );

endinterface

// File: rtl/i2c_host_bus_master.sv
// I2C host register-bus master: turns single-beat valid/ready commands into
// ADDR (as) -> DATA (as+ds) -> GAP (idle) strobe sequences and returns a
// valid/ready response carrying the captured read byte.
// Optional build macro I2C_HOST_IRQ_STATUS_EN: a rising edge on irq makes the
// master fetch SR by itself and present it on irq_status/irq_status_valid.
module i2c_host_bus_master
  import i2c_host_pkg::*;
#(
  parameter int ADDR_CYC = 2,
  parameter int DATA_CYC = 4,
  parameter int GAP_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_host_bus_master_if.master bus,
  input  logic                  irq,
  output logic                  busy
`ifdef I2C_HOST_IRQ_STATUS_EN
  ,
  output logic [7:0]            irq_status,
  output logic                  irq_status_valid
`endif
);

  // Phase lengths must fit the counter and be non-zero.
  if ((ADDR_CYC < 1) || (ADDR_CYC > CYC_MAX)) begin : g_bad_addr_cyc
    $error("ADDR_CYC must be in 1..15");
  end
  if ((DATA_CYC < 1) || (DATA_CYC > CYC_MAX)) begin : g_bad_data_cyc
    $error("DATA_CYC must be in 1..15");
  end
  if ((GAP_CYC < 1) || (GAP_CYC > CYC_MAX)) begin : g_bad_gap_cyc
    $error("GAP_CYC must be in 1..15");
  end

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [7:0] addr_q, wdata_q, rdata_q;
  logic       write_q;

  logic       accept;     // host command taken this cycle
  logic       start_int;  // internal SR read starts this cycle
  logic       capture;    // last DATA cycle: sample bus_rdata
  logic       int_go;     // internal read requested while IDLE
  logic       int_q;      // current access is the internal SR read

  // State register and phase counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and strobe decode.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    accept        = 1'b0;
    start_int     = 1'b0;
    capture       = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.as        = 1'b0;
    bus.ds        = 1'b0;
    bus.rw        = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = !int_go;
        if (int_go) begin
          start_int = 1'b1;
          state_d   = ADDR;
          cnt_d     = phase_load(ADDR_CYC);
        end else if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = ADDR;
          cnt_d   = phase_load(ADDR_CYC);
        end
      end
      ADDR: begin
        bus.as = 1'b1;
        bus.rw = write_q;
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = phase_load(DATA_CYC);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      DATA: begin
        bus.as = 1'b1;
        bus.ds = 1'b1;
        bus.rw = write_q;
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = GAP;
          cnt_d   = phase_load(GAP_CYC);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = int_q ? IDLE : RESP;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Latched command fields and the read-data capture register.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
        write_q <= bus.cmd_write;
        if (bus.cmd_write) rdata_q <= '0;
      end
      if (start_int) begin
        addr_q  <= REG_SR;
        write_q <= 1'b0;
      end
      if (capture && !write_q && !int_q) rdata_q <= bus.bus_rdata;
    end
  end

  assign bus.add_bus   = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.rsp_write = write_q;
  assign bus.rsp_rdata = rdata_q;
  assign busy          = (state_q != IDLE);

`ifdef I2C_HOST_IRQ_STATUS_EN
  logic       irq_q, pend_q;
  logic [7:0] sr_cap_q;
  logic       int_done;

  assign int_go   = pend_q;
  assign int_done = int_q && (state_q == GAP) && (cnt_q == '0);

  // irq edge detection, internal-read bookkeeping and status publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q            <= 1'b0;
      pend_q           <= 1'b0;
      int_q            <= 1'b0;
      sr_cap_q         <= '0;
      irq_status       <= '0;
      irq_status_valid <= 1'b0;
    end else begin
      irq_q            <= irq;
      irq_status_valid <= 1'b0;
      if (start_int) int_q <= 1'b1;
      if (capture && int_q) sr_cap_q <= bus.bus_rdata;
      if (int_done) begin
        int_q            <= 1'b0;
        pend_q           <= 1'b0;
        irq_status       <= sr_cap_q;
        irq_status_valid <= 1'b1;
      end
      // A fresh edge arriving during the internal read re-arms the request.
      if (irq && !irq_q) pend_q <= 1'b1;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign int_go     = 1'b0;
  assign int_q      = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_host_bus_master.sv
// Self-checking bench for i2c_host_bus_master: table of register accesses,
// hand-written multi-cycle sequences (back-to-back, stall, reset mid-access,
// optional irq status fetch) and randomized accesses against a reference model.
module tb_i2c_host_bus_master;

  localparam int A = 2;
  localparam int D = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst;
  logic irq;
  logic busy;
`ifdef I2C_HOST_IRQ_STATUS_EN
  logic [7:0] irq_status;
  logic       irq_status_valid;
  int         irq_pulses = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] slave_mem [256];

  i2c_host_bus_master_if bif ();

  i2c_host_bus_master #(
    .ADDR_CYC (A),
    .DATA_CYC (D),
    .GAP_CYC  (G)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bif),
    .irq              (irq),
    .busy             (busy)
`ifdef I2C_HOST_IRQ_STATUS_EN
    ,
    .irq_status       (irq_status),
    .irq_status_valid (irq_status_valid)
`endif
  );

  always #5 clk = ~clk;

  // Register-file slave: returns the stored byte for the current address.
  assign bif.bus_rdata = slave_mem[bif.add_bus];

`ifdef I2C_HOST_IRQ_STATUS_EN
  always @(negedge clk) if (irq_status_valid) irq_pulses <= irq_pulses + 1;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what the response byte of an access must be.
  function automatic logic [7:0] model_rdata(input logic w, input logic [7:0] slave_val);
    return w ? 8'h00 : slave_val;
  endfunction

  // One complete access, entered and left on a falling edge.
  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rdata, input int stall,
                         input bit hold_valid, output int waited);
    int as_cnt = 0, ds_cnt = 0, first_ds = 0, rsp_k = 0, k = 0;
    int bad_bus = 0, rdy_hi = 0, stall_bad = 0;
    bif.cmd_valid = 1'b1;
    bif.cmd_write = w;
    bif.cmd_addr  = a;
    bif.cmd_wdata = d;
    bif.rsp_ready = (stall == 0);
    waited = 0;
    while (!bif.cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_timeout", 32'(waited >= 100), 32'd0);
    while (rsp_k == 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (bif.as) begin
        as_cnt++;
        if (bif.add_bus !== a || bif.bus_wdata !== d || bif.rw !== w) bad_bus++;
      end
      if (bif.ds) begin
        ds_cnt++;
        if (first_ds == 0) first_ds = k;
        if (!bif.as) bad_bus++;
      end
      if (!bif.as && bif.rw) bad_bus++;
      if (bif.cmd_ready) rdy_hi++;
      if (bif.rsp_valid) rsp_k = k;
      if (k == 1) begin
        if (hold_valid) begin
          bif.cmd_addr  = ~a;
          bif.cmd_wdata = ~d;
          bif.cmd_write = ~w;
        end else begin
          bif.cmd_valid = 1'b0;
        end
      end
    end
    check("as_cycles", 32'(as_cnt), 32'(A + D));
    check("ds_cycles", 32'(ds_cnt), 32'(D));
    check("ds_first_cycle", 32'(first_ds), 32'(A + 1));
    check("rsp_latency", 32'(rsp_k), 32'(A + D + G + 1));
    check("bus_fields", 32'(bad_bus), 32'd0);
    check("cmd_ready_while_busy", 32'(rdy_hi), 32'd0);
    check("rsp_write", 32'(bif.rsp_write), 32'(w));
    check("rsp_rdata", 32'(bif.rsp_rdata), 32'(exp_rdata));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!bif.rsp_valid || bif.rsp_rdata !== exp_rdata || bif.cmd_ready || bif.as || bif.ds)
        stall_bad++;
    end
    if (stall > 0) check("stall_stable", 32'(stall_bad), 32'd0);
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    check("idle_after_rsp", {29'd0, busy, bif.cmd_ready, bif.rsp_valid}, 32'b010);
    check("rdata_hold", 32'(bif.rsp_rdata), 32'(exp_rdata));
  endtask

  typedef struct {
    logic       w;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] slave;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int         waited;
    int         rsp_seen;
    logic [7:0] reg_list [7];
    vecs[0] = '{1'b1, 8'h04, 8'h80, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h08, 8'h00, 8'hA5, 8'hA5};
    vecs[2] = '{1'b1, 8'h02, 8'h3C, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 8'h0E, 8'h00, 8'h5A, 8'h5A};
    vecs[4] = '{1'b0, 8'h00, 8'h00, 8'hC3, 8'hC3};
    vecs[5] = '{1'b1, 8'h0C, 8'hFF, 8'h99, 8'h00};
    vecs[6] = '{1'b0, 8'h0A, 8'hEE, 8'h77, 8'h77};
    reg_list = '{8'h00, 8'h02, 8'h04, 8'h08, 8'h0A, 8'h0C, 8'h0E};
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;

    rst           = 1'b1;
    irq           = 1'b0;
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = 8'h00;
    bif.cmd_wdata = 8'h00;
    bif.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("reset_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    check("reset_strobes", {29'd0, bif.as, bif.ds, bif.rw}, 32'd0);
    check("reset_rsp", {30'd0, bif.rsp_valid, bif.rsp_write}, 32'd0);
    check("reset_rsp_rdata", 32'(bif.rsp_rdata), 32'd0);
    check("reset_bus", {16'd0, bif.add_bus, bif.bus_wdata}, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven accesses
    for (int i = 0; i < 7; i++) begin
      slave_mem[vecs[i].addr] = vecs[i].slave;
      run_txn(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 0, 1'b0, waited);
    end

    // Back-to-back writes with cmd_valid held
    run_txn(1'b1, 8'h04, 8'h01, 8'h00, 0, 1'b1, waited);
    run_txn(1'b1, 8'h0E, 8'h02, 8'h00, 0, 1'b0, waited);
    check("b2b_second_accept_wait", 32'(waited), 32'd0);

    // Response stall on a read
    slave_mem[8'h08] = 8'h3E;
    run_txn(1'b0, 8'h08, 8'h00, 8'h3E, 5, 1'b0, waited);

    // Reset during the second DATA cycle
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b1;
    bif.cmd_addr  = 8'h04;
    bif.cmd_wdata = 8'h11;
    for (int k = 1; k <= A + 2; k++) begin
      @(negedge clk);
      bif.cmd_valid = 1'b0;
    end
    check("pre_reset_in_data", {30'd0, bif.as, bif.ds}, 32'b11);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_strobes", {30'd0, bif.as, bif.ds}, 32'd0);
    check("midrst_idle", {29'd0, busy, bif.cmd_ready, bif.rsp_valid}, 32'b010);
    rst = 1'b0;
    rsp_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bif.rsp_valid || busy) rsp_seen++;
    end
    check("midrst_no_response", 32'(rsp_seen), 32'd0);

    // Randomized accesses against the reference model
    for (int i = 0; i < 30; i++) begin
      logic       w;
      logic [7:0] a, d, sv;
      w  = 1'($urandom_range(0, 1));
      a  = reg_list[$urandom_range(0, 6)];
      d  = 8'($urandom);
      sv = 8'($urandom);
      slave_mem[a] = sv;
      run_txn(w, a, d, model_rdata(w, sv), $urandom_range(0, 3), 1'b0, waited);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef I2C_HOST_IRQ_STATUS_EN
    begin
      int sr_as = 0, sr_bad = 0, n = 0;
      slave_mem[8'h08] = 8'h12;
      irq = 1'b1;
      @(negedge clk);
      check("irq_pend_blocks_cmd", 32'(bif.cmd_ready), 32'd0);
      bif.cmd_valid = 1'b1;
      bif.cmd_write = 1'b1;
      bif.cmd_addr  = 8'h04;
      bif.cmd_wdata = 8'h55;
      while (!irq_status_valid && n < 40) begin
        @(negedge clk);
        n++;
        if (bif.as) begin
          sr_as++;
          if (bif.add_bus !== 8'h08 || bif.rw) sr_bad++;
        end
        if (bif.rsp_valid) sr_bad++;
      end
      check("irq_status_valid_seen", 32'(irq_status_valid), 32'd1);
      check("irq_status_value", 32'(irq_status), 32'h12);
      check("irq_sr_read_shape", 32'(sr_as), 32'(A + D));
      check("irq_sr_read_bus", 32'(sr_bad), 32'd0);
      run_txn(1'b1, 8'h04, 8'h55, 8'h00, 0, 1'b0, waited);
      check("irq_host_cmd_after", 32'(waited), 32'd0);
      repeat (10) @(negedge clk);
      check("irq_single_pulse", 32'(irq_pulses), 32'd1);
      irq = 1'b0;
      @(negedge clk);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
